// File: rtl/interrupt_controller_pkg.sv
// Shared constants, FSM encoding and vector helper for the interrupt controller.
package interrupt_controller_pkg;

    localparam logic [5:0] VEC_NMI   = 6'd62;
    localparam logic [5:0] VEC_RESET = 6'd63;
    localparam int         IDX_W     = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } state_t;

    // The reset vector is reserved for the CPU and must never reach IntAddrLSBs.
    function automatic logic [5:0] calc_vec(
        input logic             is_nmi,
        input logic [5:0]       base,
        input logic [IDX_W-1:0] idx
    );
        logic [5:0] v;
        v = base + {1'b0, idx};
        if (is_nmi || (v == VEC_RESET)) begin
            v = VEC_NMI;
        end else begin
            v = v;
        end
        return v;
    endfunction

endpackage

// File: rtl/interrupt_controller_priority_encoder.sv
// Combinational highest-set-bit encoder used to pick the winning maskable source.
module irq_priority_encoder
    import interrupt_controller_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan upward so the highest set index is the one left standing.
    always_comb begin
        valid = 1'b0;
        idx   = {IDX_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            valid = valid | req[i];
            idx   = req[i] ? IDX_W'(i) : idx;
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-captured interrupt sources, fixed-priority arbitration and INTACK handshake.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int NUM_SRC  = 16,
    parameter int BASE_VEC = 32
) (
    input  logic               MCLK,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [NUM_SRC-1:0] irq_ie,
    input  logic [NUM_SRC-1:0] clr_pend,
    input  logic               nmi_in,
    input  logic               INTACK,
    output logic               NMI,
    output logic               INT,
    output logic [5:0]         IntAddrLSBs,
    output logic [NUM_SRC-1:0] irq_ack,
    output logic [NUM_SRC-1:0] pending
);

    localparam logic [5:0]         BASE_V  = 6'(BASE_VEC);
    localparam logic [NUM_SRC-1:0] SRC_ONE = NUM_SRC'(1'b1);

    state_t               state_r, state_nxt_s;
    logic [NUM_SRC-1:0]   irq_q_r, pending_r, irq_ack_r, ack_nxt_s;
    logic                 nmi_q_r, nmi_pend_r, nmi_ack_r, nmi_ack_nxt_s;
    logic                 nmi_out_r, int_out_r, nmi_out_nxt_s, int_out_nxt_s;
    logic [5:0]           vec_r, vec_nxt_s;
    logic                 win_nmi_r, win_nmi_nxt_s;
    logic [IDX_W-1:0]     win_idx_r, win_idx_nxt_s;
    logic [NUM_SRC-1:0]   cand_s;
    logic                 enc_valid_s, arb_valid_s;
    logic [IDX_W-1:0]     enc_idx_s;
    logic [5:0]           arb_vec_s;

    assign cand_s      = pending_r & irq_ie;
    assign arb_valid_s = nmi_pend_r | enc_valid_s;
    assign arb_vec_s   = calc_vec(nmi_pend_r, BASE_V, enc_idx_s);

    irq_priority_encoder #(.N(NUM_SRC)) u_prio (
        .req   (cand_s),
        .valid (enc_valid_s),
        .idx   (enc_idx_s)
    );

    // Edge capture; a fresh edge overrides a same-cycle clear so no event is lost.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            irq_q_r    <= {NUM_SRC{1'b0}};
            pending_r  <= {NUM_SRC{1'b0}};
            nmi_q_r    <= 1'b0;
            nmi_pend_r <= 1'b0;
        end else begin
            irq_q_r    <= irq_in;
            pending_r  <= (pending_r & ~(clr_pend | irq_ack_r)) | (irq_in & ~irq_q_r);
            nmi_q_r    <= nmi_in;
            nmi_pend_r <= (nmi_pend_r & ~nmi_ack_r) | (nmi_in & ~nmi_q_r);
        end
    end

    // FSM state and registered CPU-facing outputs.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            state_r   <= IDLE;
            nmi_out_r <= 1'b0;
            int_out_r <= 1'b0;
            vec_r     <= 6'd0;
            win_nmi_r <= 1'b0;
            win_idx_r <= {IDX_W{1'b0}};
            irq_ack_r <= {NUM_SRC{1'b0}};
            nmi_ack_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            nmi_out_r <= nmi_out_nxt_s;
            int_out_r <= int_out_nxt_s;
            vec_r     <= vec_nxt_s;
            win_nmi_r <= win_nmi_nxt_s;
            win_idx_r <= win_idx_nxt_s;
            irq_ack_r <= ack_nxt_s;
            nmi_ack_r <= nmi_ack_nxt_s;
        end
    end

    // Next-state logic; an acknowledge services the winner the CPU was shown.
    always_comb begin
        state_nxt_s   = state_r;
        nmi_out_nxt_s = 1'b0;
        int_out_nxt_s = 1'b0;
        vec_nxt_s     = vec_r;
        win_nmi_nxt_s = win_nmi_r;
        win_idx_nxt_s = win_idx_r;
        ack_nxt_s     = {NUM_SRC{1'b0}};
        nmi_ack_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (arb_valid_s) begin
                    state_nxt_s   = REQ;
                    win_nmi_nxt_s = nmi_pend_r;
                    win_idx_nxt_s = enc_idx_s;
                    vec_nxt_s     = arb_vec_s;
                    nmi_out_nxt_s = nmi_pend_r;
                    int_out_nxt_s = ~nmi_pend_r;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (INTACK) begin
                    state_nxt_s = ACK;
                    if (win_nmi_r) begin
                        nmi_ack_nxt_s = 1'b1;
                    end else begin
                        ack_nxt_s = SRC_ONE << win_idx_r;
                    end
                end else if (arb_valid_s) begin
                    win_nmi_nxt_s = nmi_pend_r;
                    win_idx_nxt_s = enc_idx_s;
                    vec_nxt_s     = arb_vec_s;
                    nmi_out_nxt_s = nmi_pend_r;
                    int_out_nxt_s = ~nmi_pend_r;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACK: begin
                if (INTACK) begin
                    state_nxt_s = ACK;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign NMI         = nmi_out_r;
    assign INT         = int_out_r;
    assign IntAddrLSBs = vec_r;
    assign irq_ack     = irq_ack_r;
    assign pending     = pending_r;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller (NUM_SRC=16, BASE_VEC=32).
module tb_interrupt_controller;

    logic        MCLK = 1'b0;
    logic        reset;
    logic [15:0] irq_in, irq_ie, clr_pend;
    logic        nmi_in, INTACK;
    logic        NMI, INT;
    logic [5:0]  IntAddrLSBs;
    logic [15:0] irq_ack, pending;

    int checks = 0;
    int errors = 0;

    interrupt_controller #(.NUM_SRC(16), .BASE_VEC(32)) dut (
        .MCLK        (MCLK),
        .reset       (reset),
        .irq_in      (irq_in),
        .irq_ie      (irq_ie),
        .clr_pend    (clr_pend),
        .nmi_in      (nmi_in),
        .INTACK      (INTACK),
        .NMI         (NMI),
        .INT         (INT),
        .IntAddrLSBs (IntAddrLSBs),
        .irq_ack     (irq_ack),
        .pending     (pending)
    );

    always #5 MCLK = ~MCLK;

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; irq_in = 16'h0; irq_ie = 16'hFFFF; clr_pend = 16'h0;
        nmi_in = 1'b0; INTACK = 1'b0;
        tick(); tick();
        checks++;
        if ({NMI, INT} !== 2'b00) begin errors++; $display("FAIL reset_req got %b exp 00", {NMI, INT}); end
        checks++;
        if (IntAddrLSBs !== 6'd0) begin errors++; $display("FAIL reset_vec got %0d exp 0", IntAddrLSBs); end
        checks++;
        if ({irq_ack, pending} !== 32'h0) begin errors++; $display("FAIL reset_ack_pend got %h exp 0", {irq_ack, pending}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        irq_in = 16'h0008;
        tick();
        checks++;
        if (pending !== 16'h0008 || INT !== 1'b0) begin errors++; $display("FAIL single_pend got pend=%h INT=%b exp 0008/0", pending, INT); end
        tick();
        checks++;
        if (INT !== 1'b1 || NMI !== 1'b0 || IntAddrLSBs !== 6'd35) begin errors++; $display("FAIL single_req got INT=%b NMI=%b vec=%0d exp 1/0/35", INT, NMI, IntAddrLSBs); end
        INTACK = 1'b1;
        tick();
        checks++;
        if (irq_ack !== 16'h0008 || INT !== 1'b0 || IntAddrLSBs !== 6'd35) begin errors++; $display("FAIL single_ack got ack=%h INT=%b vec=%0d exp 0008/0/35", irq_ack, INT, IntAddrLSBs); end
        tick();
        checks++;
        if (irq_ack !== 16'h0 || pending !== 16'h0 || INT !== 1'b0) begin errors++; $display("FAIL single_ack_once got ack=%h pend=%h INT=%b exp 0/0/0", irq_ack, pending, INT); end
        tick();
        INTACK = 1'b0; irq_in = 16'h0;
        tick(); tick();
        checks++;
        if (INT !== 1'b0 || irq_ack !== 16'h0) begin errors++; $display("FAIL single_idle got INT=%b ack=%h exp 0/0", INT, irq_ack); end
    endtask

    task automatic test_priority();
        irq_in = 16'h0204;
        tick(); tick();
        checks++;
        if (INT !== 1'b1 || IntAddrLSBs !== 6'd41) begin errors++; $display("FAIL prio_first got INT=%b vec=%0d exp 1/41", INT, IntAddrLSBs); end
        INTACK = 1'b1;
        tick();
        checks++;
        if (irq_ack !== 16'h0200) begin errors++; $display("FAIL prio_ack9 got %h exp 0200", irq_ack); end
        INTACK = 1'b0;
        tick();
        checks++;
        if (INT !== 1'b0 || pending !== 16'h0004) begin errors++; $display("FAIL prio_gap got INT=%b pend=%h exp 0/0004", INT, pending); end
        tick();
        checks++;
        if (INT !== 1'b1 || IntAddrLSBs !== 6'd34) begin errors++; $display("FAIL prio_second got INT=%b vec=%0d exp 1/34", INT, IntAddrLSBs); end
        INTACK = 1'b1;
        tick();
        checks++;
        if (irq_ack !== 16'h0004) begin errors++; $display("FAIL prio_ack2 got %h exp 0004", irq_ack); end
        INTACK = 1'b0; irq_in = 16'h0;
        tick(); tick();
        checks++;
        if (INT !== 1'b0 || pending !== 16'h0 || irq_ack !== 16'h0) begin errors++; $display("FAIL prio_done got INT=%b pend=%h ack=%h exp 0/0/0", INT, pending, irq_ack); end
    endtask

    task automatic test_nmi();
        irq_in = 16'h0020;
        tick(); tick();
        checks++;
        if (INT !== 1'b1 || IntAddrLSBs !== 6'd37) begin errors++; $display("FAIL nmi_pre got INT=%b vec=%0d exp 1/37", INT, IntAddrLSBs); end
        nmi_in = 1'b1;
        tick(); tick();
        checks++;
        if (NMI !== 1'b1 || INT !== 1'b0 || IntAddrLSBs !== 6'd62) begin errors++; $display("FAIL nmi_preempt got NMI=%b INT=%b vec=%0d exp 1/0/62", NMI, INT, IntAddrLSBs); end
        INTACK = 1'b1;
        tick();
        checks++;
        if (NMI !== 1'b0 || irq_ack !== 16'h0 || IntAddrLSBs !== 6'd62) begin errors++; $display("FAIL nmi_ack got NMI=%b ack=%h vec=%0d exp 0/0/62", NMI, irq_ack, IntAddrLSBs); end
        tick();
        checks++;
        if (pending !== 16'h0020) begin errors++; $display("FAIL nmi_keep5 got %h exp 0020", pending); end
        INTACK = 1'b0; nmi_in = 1'b0;
        tick(); tick();
        checks++;
        if (NMI !== 1'b0 || INT !== 1'b1 || IntAddrLSBs !== 6'd37) begin errors++; $display("FAIL nmi_cleared got NMI=%b INT=%b vec=%0d exp 0/1/37", NMI, INT, IntAddrLSBs); end
        INTACK = 1'b1;
        tick();
        checks++;
        if (irq_ack !== 16'h0020) begin errors++; $display("FAIL nmi_ack5 got %h exp 0020", irq_ack); end
        INTACK = 1'b0; irq_in = 16'h0;
        tick(); tick();
    endtask

    task automatic test_masking();
        irq_ie = 16'hFF7F; irq_in = 16'h0080;
        tick(); tick(); tick();
        checks++;
        if (pending !== 16'h0080 || INT !== 1'b0) begin errors++; $display("FAIL mask_hold got pend=%h INT=%b exp 0080/0", pending, INT); end
        INTACK = 1'b1;
        tick();
        checks++;
        if (irq_ack !== 16'h0 || INT !== 1'b0 || NMI !== 1'b0) begin errors++; $display("FAIL spurious_ack got ack=%h INT=%b NMI=%b exp 0/0/0", irq_ack, INT, NMI); end
        INTACK = 1'b0; irq_ie = 16'hFFFF;
        tick();
        checks++;
        if (INT !== 1'b1 || IntAddrLSBs !== 6'd39) begin errors++; $display("FAIL unmask_req got INT=%b vec=%0d exp 1/39", INT, IntAddrLSBs); end
        irq_ie = 16'hFF7F;
        tick();
        checks++;
        if (INT !== 1'b0 || pending !== 16'h0080) begin errors++; $display("FAIL mask_in_req got INT=%b pend=%h exp 0/0080", INT, pending); end
        irq_ie = 16'hFFFF;
        tick();
        INTACK = 1'b1;
        tick();
        checks++;
        if (irq_ack !== 16'h0080) begin errors++; $display("FAIL mask_ack7 got %h exp 0080", irq_ack); end
        INTACK = 1'b0; irq_in = 16'h0;
        tick();
        checks++;
        if (pending !== 16'h0) begin errors++; $display("FAIL mask_clear got %h exp 0", pending); end
        tick();
    endtask

    task automatic test_collision();
        irq_in = 16'h0010;
        tick(); tick();
        checks++;
        if (INT !== 1'b1 || IntAddrLSBs !== 6'd36) begin errors++; $display("FAIL coll_req got INT=%b vec=%0d exp 1/36", INT, IntAddrLSBs); end
        irq_in = 16'h0; INTACK = 1'b1;
        tick();
        checks++;
        if (irq_ack !== 16'h0010) begin errors++; $display("FAIL coll_ack got %h exp 0010", irq_ack); end
        irq_in = 16'h0010; INTACK = 1'b0;
        tick();
        checks++;
        if (pending !== 16'h0010) begin errors++; $display("FAIL coll_ack_setwins got %h exp 0010", pending); end
        tick();
        checks++;
        if (INT !== 1'b1 || IntAddrLSBs !== 6'd36) begin errors++; $display("FAIL coll_second got INT=%b vec=%0d exp 1/36", INT, IntAddrLSBs); end
        INTACK = 1'b1;
        tick();
        INTACK = 1'b0;
        tick();
        checks++;
        if (pending !== 16'h0) begin errors++; $display("FAIL coll_second_clr got %h exp 0", pending); end
        irq_ie = 16'hFFEF; irq_in = 16'h0;
        tick();
        irq_in = 16'h0010;
        tick();
        irq_in = 16'h0;
        tick();
        irq_in = 16'h0010; clr_pend = 16'h0010;
        tick();
        checks++;
        if (pending !== 16'h0010) begin errors++; $display("FAIL coll_clr_setwins got %h exp 0010", pending); end
        tick();
        checks++;
        if (pending !== 16'h0) begin errors++; $display("FAIL clr_pend got %h exp 0", pending); end
        clr_pend = 16'h0; irq_in = 16'h0; irq_ie = 16'hFFFF;
        tick();
    endtask

    task automatic test_reset_mid();
        irq_in = 16'h0002;
        tick(); tick();
        checks++;
        if (INT !== 1'b1 || IntAddrLSBs !== 6'd33) begin errors++; $display("FAIL rmid_req got INT=%b vec=%0d exp 1/33", INT, IntAddrLSBs); end
        INTACK = 1'b1;
        tick();
        checks++;
        if (irq_ack !== 16'h0002) begin errors++; $display("FAIL rmid_ack got %h exp 0002", irq_ack); end
        reset = 1'b1; irq_in = 16'h0;
        tick();
        checks++;
        if ({NMI, INT, IntAddrLSBs, irq_ack, pending} !== 40'h0) begin errors++; $display("FAIL rmid_reset got NMI=%b INT=%b vec=%0d ack=%h pend=%h exp all 0", NMI, INT, IntAddrLSBs, irq_ack, pending); end
        reset = 1'b0;
        tick();
        INTACK = 1'b0;
        tick();
        checks++;
        if (irq_ack !== 16'h0 || INT !== 1'b0) begin errors++; $display("FAIL rmid_noack got ack=%h INT=%b exp 0/0", irq_ack, INT); end
        tick();
        checks++;
        if (irq_ack !== 16'h0 || INT !== 1'b0 || NMI !== 1'b0) begin errors++; $display("FAIL rmid_quiet got ack=%h INT=%b NMI=%b exp 0/0/0", irq_ack, INT, NMI); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_nmi();
        test_masking();
        test_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
